// File: rtl/niosii_system_edge_poll_master.sv
// Avalon-MM initiator that polls an edge-capturing PIO, clears the captured
// bits (write-1-to-clear) and queues each non-zero event mask in a show-ahead FIFO.
module niosii_system_edge_poll_master #(
    parameter int POLL_PERIOD = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    output logic [1:0]                    m_address,
    output logic                          m_chipselect,
    output logic                          m_write_n,
    output logic [31:0]                   m_writedata,
    input  logic [31:0]                   m_readdata,
    output logic                          evt_valid,
    output logic [7:0]                    evt_data,
    input  logic                          evt_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int TW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] RELOAD = TW'(POLL_PERIOD - 1);
    localparam logic [1:0]    EDGE_CAP_ADDR = 2'd3;

    typedef enum logic [2:0] {IDLE, READ, WAIT, CLEAR, PUSH} state_t;

    state_t        state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [7:0]    cap, cap_d;
    logic          cs_d, write_n_d;
    logic [1:0]    addr_d;
    logic [7:0]    wdata_d, wdata_q;

    // Timer keeps running through the poll so READ starts stay exactly POLL_PERIOD apart.
    always_comb begin
        state_d   = state;
        timer_d   = (timer != '0) ? timer - TW'(1) : timer;
        cap_d     = cap;
        cs_d      = 1'b0;
        write_n_d = 1'b1;
        addr_d    = '0;
        wdata_d   = '0;
        case (state)
            IDLE: begin
                if (!enable) begin
                    timer_d = RELOAD;
                end else if (timer == '0) begin
                    state_d = READ;
                    timer_d = RELOAD;
                end
            end
            READ:  state_d = WAIT;
            WAIT: begin
                cap_d   = m_readdata[7:0];
                state_d = (m_readdata[7:0] == '0) ? IDLE : CLEAR;
            end
            CLEAR: state_d = PUSH;
            PUSH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        case (state_d)
            READ: begin
                cs_d   = 1'b1;
                addr_d = EDGE_CAP_ADDR;
            end
            CLEAR: begin
                cs_d      = 1'b1;
                write_n_d = 1'b0;
                addr_d    = EDGE_CAP_ADDR;
                wdata_d   = cap_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            timer        <= RELOAD;
            cap          <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_address    <= '0;
            wdata_q      <= '0;
        end else begin
            state        <= state_d;
            timer        <= timer_d;
            cap          <= cap_d;
            m_chipselect <= cs_d;
            m_write_n    <= write_n_d;
            m_address    <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign m_writedata = {24'b0, wdata_q};

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic          push, pop, full, accept;

    assign push   = (state == PUSH);
    assign pop    = evt_ready && (level != '0);
    assign full   = (level == (AW+1)'(FIFO_DEPTH));
    assign accept = push && (!full || pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)      level <= level + (AW+1)'(1);
            else if (!accept && pop) level <= level - (AW+1)'(1);
            if (push && !accept)     overflow <= 1'b1;
            else if (clr_overflow)   overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= cap;
    end

    assign evt_valid  = (level != '0);
    assign evt_data   = (level != '0) ? mem[rd_ptr] : '0;
    assign fifo_level = level;

endmodule

// File: tb/tb_niosii_system_edge_poll_master.sv
// Scoreboard bench: stimulus queues expected bus cycles and events, monitors
// pop and compare whenever the master drives the bus or an event is consumed.
module tb_niosii_system_edge_poll_master;

    localparam int P = 8;
    localparam int D = 2;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b1;
    logic [1:0]         m_address;
    logic               m_chipselect;
    logic               m_write_n;
    logic [31:0]        m_writedata;
    logic [31:0]        m_readdata = '0;
    logic               evt_valid;
    logic [7:0]         evt_data;
    logic               evt_ready = 1'b0;
    logic [$clog2(D):0] fifo_level;
    logic               overflow;
    logic               clr_overflow = 1'b0;

    niosii_system_edge_poll_master #(.POLL_PERIOD(P), .FIFO_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
        .m_writedata(m_writedata), .m_readdata(m_readdata),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
        .fifo_level(fifo_level), .overflow(overflow), .clr_overflow(clr_overflow)
    );

    always #5 clk = ~clk;

    // Edge-capture PIO slave model: registered read, write-1-to-clear, new edges win
    logic [7:0] slv_cap = '0;
    logic [7:0] edge_in = '0;
    always @(posedge clk) begin
        if (m_chipselect && m_write_n && m_address == 2'd3)
            m_readdata <= {24'b0, slv_cap};
        if (m_chipselect && !m_write_n && m_address == 2'd3)
            slv_cap <= (slv_cap & ~m_writedata[7:0]) | edge_in;
        else
            slv_cap <= slv_cap | edge_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic       wr;
        logic [7:0] data;
        int         delta;
    } bus_t;

    bus_t       bq[$];
    logic [7:0] eq[$];
    int         bus_seen = 0;

    // delta: cycles since previous READ (0 = not timed); writes are always 2 after READ
    task automatic exp_rd(input int d);
        bus_t b;
        b.wr = 1'b0; b.data = '0; b.delta = d;
        bq.push_back(b);
    endtask

    task automatic exp_wr(input logic [7:0] v);
        bus_t b;
        b.wr = 1'b1; b.data = v; b.delta = 2;
        bq.push_back(b);
    endtask

    initial begin : bus_monitor
        int   last_read;
        logic prev_cs;
        bus_t b;
        last_read = 0;
        prev_cs = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                last_read = cyc;
                prev_cs = 1'b0;
            end else if (m_chipselect) begin
                bus_seen++;
                check("cs_back_to_back", {31'b0, prev_cs}, 32'd0);
                if (bq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_bus actual=write_n:%0b data:0x%0h required=no_cycle at cycle %0d",
                             m_write_n, m_writedata, cyc);
                end else begin
                    b = bq.pop_front();
                    check("bus_is_write", {31'b0, !m_write_n}, {31'b0, b.wr});
                    check("bus_addr", {30'b0, m_address}, 32'd3);
                    check("bus_wdata", m_writedata, b.wr ? {24'b0, b.data} : 32'd0);
                    if (b.wr) begin
                        check("clear_latency", cyc - last_read, 32'd2);
                    end else begin
                        if (b.delta != 0) check("read_spacing", cyc - last_read, b.delta);
                        last_read = cyc;
                    end
                end
                prev_cs = 1'b1;
            end else begin
                check("bus_idle", {m_write_n, m_address, m_writedata}, {1'b1, 2'b0, 32'b0});
                prev_cs = 1'b0;
            end
        end
    end

    initial begin : evt_monitor
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && evt_valid && evt_ready) begin
                if (eq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pop actual=0x%0h required=no_event", evt_data);
                end else begin
                    e = eq.pop_front();
                    check("evt_pop_data", {24'b0, evt_data}, {24'b0, e});
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_read();
        for (int k = 0; k < 40; k++) begin
            tick();
            if (m_chipselect && m_write_n) return;
        end
        checks++;
        failures++;
        $display("FAIL read_timeout actual=no_read required=read_within_40 at cycle %0d", cyc);
    endtask

    initial begin : stimulus
        int seen;
        tick(3);
        check("rst_addr", {30'b0, m_address}, 32'd0);
        check("rst_cs", {31'b0, m_chipselect}, 32'd0);
        check("rst_write_n", {31'b0, m_write_n}, 32'd1);
        check("rst_wdata", m_writedata, 32'd0);
        check("rst_evt_valid", {31'b0, evt_valid}, 32'd0);
        check("rst_evt_data", {24'b0, evt_data}, 32'd0);
        check("rst_level", {30'b0, fifo_level}, 32'd0);
        check("rst_overflow", {31'b0, overflow}, 32'd0);

        // Idle polling: slave returns 0
        exp_rd(9); exp_rd(8); exp_rd(8);
        reset_n = 1'b1;
        wait_read();
        check("idle_evt_valid", {31'b0, evt_valid}, 32'd0);
        wait_read();
        wait_read();

        // Single event 0x05
        tick(2);
        edge_in = 8'h05; exp_rd(8); exp_wr(8'h05);
        tick(); edge_in = '0;
        wait_read();
        tick(3);
        check("evt_not_yet_valid", {31'b0, evt_valid}, 32'd0);
        tick();
        check("evt_valid_after_4", {31'b0, evt_valid}, 32'd1);
        check("evt_data_05", {24'b0, evt_data}, 32'h05);
        eq.push_back(8'h05); evt_ready = 1'b1;
        tick(); evt_ready = 1'b0;
        check("evt_valid_after_pop", {31'b0, evt_valid}, 32'd0);

        // Partial clear: read 0x01, bit 2 arrives before CLEAR
        edge_in = 8'h01; exp_rd(8); exp_wr(8'h01); exp_rd(8); exp_wr(8'h04);
        tick(); edge_in = '0;
        wait_read();
        edge_in = 8'h04;
        tick(); edge_in = '0;
        wait_read();
        tick(4);
        check("partial_level", {30'b0, fifo_level}, 32'd2);
        check("partial_head", {24'b0, evt_data}, 32'h01);

        // FIFO full: drop 0x02, then drop 0x08 with clr_overflow in the same cycle
        edge_in = 8'h02; exp_rd(8); exp_wr(8'h02);
        tick(); edge_in = '0;
        wait_read();
        tick(4);
        check("ovf_set", {31'b0, overflow}, 32'd1);
        check("ovf_level", {30'b0, fifo_level}, 32'd2);
        edge_in = 8'h08; exp_rd(8); exp_wr(8'h08);
        tick(); edge_in = '0;
        wait_read();
        tick(3); clr_overflow = 1'b1;
        tick(); clr_overflow = 1'b0;
        check("ovf_set_wins", {31'b0, overflow}, 32'd1);
        clr_overflow = 1'b1;
        tick(); clr_overflow = 1'b0;
        check("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Full with simultaneous pop: push 0x10 accepted
        edge_in = 8'h10; exp_rd(8); exp_wr(8'h10);
        tick(); edge_in = '0;
        wait_read();
        tick(3); evt_ready = 1'b1; eq.push_back(8'h01);
        tick(); evt_ready = 1'b0;
        check("fullpop_level", {30'b0, fifo_level}, 32'd2);
        check("fullpop_overflow", {31'b0, overflow}, 32'd0);
        check("fullpop_head", {24'b0, evt_data}, 32'h04);
        eq.push_back(8'h04); eq.push_back(8'h10); evt_ready = 1'b1;
        tick(2); evt_ready = 1'b0;
        check("drain_level", {30'b0, fifo_level}, 32'd0);
        check("drain_valid", {31'b0, evt_valid}, 32'd0);

        // Enable dropped during WAIT with cap 0x80
        edge_in = 8'h80; exp_rd(8); exp_wr(8'h80);
        tick(); edge_in = '0;
        wait_read();
        tick(); enable = 1'b0;
        tick(3);
        check("dis_evt_valid", {31'b0, evt_valid}, 32'd1);
        check("dis_evt_data", {24'b0, evt_data}, 32'h80);
        seen = bus_seen;
        tick(24);
        check("dis_no_read", bus_seen, seen);
        check("dis_level", {30'b0, fifo_level}, 32'd1);

        // Reset pulse during CLEAR
        exp_rd(0); enable = 1'b1; edge_in = 8'h40;
        tick(); edge_in = '0;
        wait_read();
        tick(2);
        check("clear_cs", {31'b0, m_chipselect}, 32'd1);
        check("clear_write_n", {31'b0, m_write_n}, 32'd0);
        check("clear_wdata", m_writedata, 32'h40);
        reset_n = 1'b0;
        #1;
        check("async_cs", {31'b0, m_chipselect}, 32'd0);
        check("async_write_n", {31'b0, m_write_n}, 32'd1);
        check("async_level", {30'b0, fifo_level}, 32'd0);
        check("async_evt_valid", {31'b0, evt_valid}, 32'd0);
        exp_rd(9); exp_wr(8'h40);
        tick(); reset_n = 1'b1;
        wait_read();
        tick(4);
        check("post_rst_valid", {31'b0, evt_valid}, 32'd1);
        check("post_rst_data", {24'b0, evt_data}, 32'h40);
        eq.push_back(8'h40); evt_ready = 1'b1;
        tick(); evt_ready = 1'b0; enable = 1'b0;
        tick(4);
        check("bus_queue_empty", bq.size(), 32'd0);
        check("evt_queue_empty", eq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/niosii_system_edge_poll_master.md
# niosII_system_edge_poll_master

Avalon-MM initiator that services an edge-capturing input PIO slave (8-bit, edge-capture register at word address 3) without CPU involvement. It polls the slave's edge-capture register on a fixed period. When any captured bit is set, it acknowledges exactly those bits by writing them back (write-1-to-clear) and pushes the 8-bit event mask into a show-ahead FIFO for downstream logic. It sits in the Nios II system beside the button PIO and drives that PIO's slave port directly.

## Interface
- POLL_PERIOD, 50000: clock cycles between poll starts (≥4).
- FIFO_DEPTH, 8: event FIFO entries (power of 2, ≥2).
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  polling enabled when high.
- m_address  out  2  slave word address.
- m_chipselect  out  1  slave select.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  32  write data; upper 24 bits always 0.
- m_readdata  in  32  slave read data; registered by the slave, valid the cycle after address is presented.
- evt_valid  out  1  FIFO non-empty.
- evt_data  out  8  head-of-FIFO event mask (show-ahead).
- evt_ready  in  1  consumer pop; pop occurs when evt_valid && evt_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count.
- overflow  out  1  sticky; event dropped because FIFO full.
- clr_overflow  in  1  synchronous clear of overflow.

## Operation
- FSM states: IDLE, READ, WAIT, CLEAR, PUSH.
- IDLE:
  - Poll timer counts down from POLL_PERIOD-1.
  - At 0 with enable=1 → READ; timer reloads.
  - enable=0 holds the timer at reload and stays in IDLE.
- READ (1 cycle): m_address=3, m_chipselect=1, m_write_n=1 → WAIT.
- WAIT (1 cycle): capture cap = m_readdata[7:0].
  - cap==0 → IDLE.
  - cap!=0 → CLEAR.
- CLEAR (1 cycle): m_address=3, m_chipselect=1, m_write_n=0, m_writedata={24'b0,cap} → PUSH.
  - Only captured bits are cleared; other pending bits are untouched.
- PUSH (1 cycle): write cap into FIFO if space, else set overflow → IDLE.
  - The CLEAR write is issued even when the event is dropped, so the slave IRQ still deasserts.
- Outside READ/CLEAR: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- enable deasserted mid-poll: the current poll completes through PUSH; no new poll starts.
- FIFO rules:
  - A push is accepted when level<FIFO_DEPTH, or when level==FIFO_DEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - A pop when empty is ignored.
- overflow: set on a rejected push, cleared by clr_overflow; set wins if both occur in the same cycle.
- Known limitation: an edge on bit k arriving between READ and CLEAR, with cap[k]=1, is absorbed by the clear. This is accepted.

## Timing
- Reset values:
  - m_address=0, m_chipselect=0, m_write_n=1, m_writedata=0.
  - evt_valid=0, evt_data=0, fifo_level=0, overflow=0.
  - FSM=IDLE; timer=POLL_PERIOD-1.
- Reset assertion mid-poll aborts any bus cycle immediately; the FIFO is emptied.
- Poll start spacing: exactly POLL_PERIOD cycles between READ entries while enable=1, independent of the poll path taken (a poll takes 2 or 4 cycles, well under POLL_PERIOD).
- Latency:
  - READ cycle to m_readdata sample (WAIT): 1 cycle.
  - To CLEAR write: 2 cycles.
  - To evt_valid high (empty FIFO): 4 cycles after READ (pushed at PUSH edge, visible the next cycle).
- Per-bus-cycle rule: every bus cycle lasts exactly one clock; chipselect is never asserted on two consecutive cycles.
- All outputs are registered except evt_valid/evt_data/fifo_level, which decode directly from the FIFO registers.

## Test plan
- Reset/idle: POLL_PERIOD=8, enable=1, slave returns 0 → READ at address 3 every 8 cycles, no write ever, evt_valid stays 0.
- Single event: slave edge-capture=0x05 → write of 0x00000005 to address 3 two cycles after READ; evt_data=0x05 and evt_valid=1 four cycles after READ; evt_ready pop → evt_valid=0.
- Partial clear: capture reads 0x01, then bit 2 set before CLEAR → write data 0x01; next poll reads 0x04 and pushes 0x04.
- FIFO full: FIFO_DEPTH=2, evt_ready=0, three events 0x01,0x02,0x04 → FIFO holds 0x01,0x02, overflow=1, third CLEAR still issued; clr_overflow simultaneous with a fourth drop → overflow stays 1.
- Full with pop: level=2, push coincides with evt_ready=1 → push accepted, level stays 2, overflow stays 0.
- Enable/reset: enable dropped during WAIT with cap=0x80 → CLEAR and PUSH complete, no further READ; reset_n pulse during CLEAR → chipselect=0 asynchronously, fifo_level=0.
